// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative sequencer for MIPS mult/multu/div/divu.
// Accepts one operation at a time over a valid/ready handshake. It runs 32
// shift-add (multiply) or restoring shift-subtract (divide) iterations, then
// applies sign correction. The {HI, LO} result is held until it is consumed.
//
// Ports:
//   i_clk, i_reset     clock, synchronous active-high reset
//   i_req_valid/o_req_ready, i_req_op, i_src_a, i_src_b   request side
//                      op: 00 mult, 01 multu, 10 div, 11 divu
//   i_flush            abort any operation in flight, no result produced
//   o_busy             high whenever not IDLE (EX stall)
//   o_res_valid/i_res_ready, o_res_hi, o_res_lo           result side
//
// state  | meaning
// IDLE   | waiting for a request, req_ready high
// RUN    | one multiply/divide iteration per cycle, cnt 0..31
// FIX    | sign correction / divide-by-zero override, load result
// DONE   | result presented until res_ready
module muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic [1:0]      i_req_op,
  input  logic [XLEN-1:0] i_src_a,
  input  logic [XLEN-1:0] i_src_b,
  input  logic            i_flush,
  output logic            o_busy,
  output logic            o_res_valid,
  input  logic            i_res_ready,
  output logic [XLEN-1:0] o_res_hi,
  output logic [XLEN-1:0] o_res_lo
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_is_div;
  logic                r_sa;
  logic                r_sb;
  logic                r_b_zero;
  logic [XLEN-1:0]     r_a_raw;   // unmodified dividend, returned as HI on divide by zero
  logic [XLEN-1:0]     r_a;       // |multiplicand|
  logic [XLEN-1:0]     r_b;       // |divisor|
  logic [2*XLEN-1:0]   r_acc;     // multiply accumulator: {partial product, remaining multiplier}
  logic [XLEN-1:0]     r_rem;     // divide partial remainder
  logic [XLEN-1:0]     r_quo;     // divide: dividend shifts out of the top, quotient shifts in at the bottom
  logic                r_req_ready;
  logic                r_busy;
  logic                r_res_valid;
  logic [XLEN-1:0]     r_res_hi;
  logic [XLEN-1:0]     r_res_lo;

  // Request decode: op[0]=1 means unsigned, op[1]=1 means divide.
  logic                w_signed;
  logic                w_sa_in;
  logic                w_sb_in;
  logic [XLEN-1:0]     w_mag_a;
  logic [XLEN-1:0]     w_mag_b;

  assign w_signed = ~i_req_op[0];
  assign w_sa_in  = i_src_a[XLEN-1] & w_signed;
  assign w_sb_in  = i_src_b[XLEN-1] & w_signed;
  assign w_mag_a  = w_sa_in ? -i_src_a : i_src_a;
  assign w_mag_b  = w_sb_in ? -i_src_b : i_src_b;

  // Multiply step: add multiplicand into the upper half when the multiplier
  // LSB is set, then shift the whole accumulator right by one. The carry out
  // of the add becomes the new MSB.
  logic [XLEN-1:0]     w_addend;
  logic [XLEN:0]       w_sum;
  logic [2*XLEN-1:0]   w_acc_next;

  assign w_addend   = r_acc[0] ? r_a : '0;
  assign w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, w_addend};
  assign w_acc_next = {w_sum, r_acc[XLEN-1:1]};

  // Restoring divide step on a 33-bit partial remainder. The remainder is
  // always below the divisor, so after a subtract it fits in XLEN bits again.
  logic [XLEN:0]       w_shift;
  logic                w_ge;
  logic [XLEN-1:0]     w_rem_next;
  logic [XLEN-1:0]     w_quo_next;

  assign w_shift    = {r_rem, r_quo[XLEN-1]};
  assign w_ge       = (w_shift >= {1'b0, r_b});
  assign w_rem_next = w_ge ? XLEN'(w_shift - {1'b0, r_b}) : w_shift[XLEN-1:0];
  assign w_quo_next = {r_quo[XLEN-2:0], w_ge};

  // Sign correction. The quotient takes the XOR of the operand signs and the
  // remainder takes the dividend's sign. 0x80000000 / -1 falls out naturally
  // as 0x80000000 with a zero remainder.
  logic [2*XLEN-1:0]   w_prod_fix;
  logic [XLEN-1:0]     w_quo_fix;
  logic [XLEN-1:0]     w_rem_fix;

  assign w_prod_fix = (r_sa ^ r_sb) ? -r_acc : r_acc;
  assign w_quo_fix  = (r_sa ^ r_sb) ? -r_quo : r_quo;
  assign w_rem_fix  = r_sa ? -r_rem : r_rem;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_is_div    <= 1'b0;
      r_sa        <= 1'b0;
      r_sb        <= 1'b0;
      r_b_zero    <= 1'b0;
      r_a_raw     <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_req_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_hi    <= '0;
      r_res_lo    <= '0;
    end else if (i_flush) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_req_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_res_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_state     <= S_RUN;
            r_cnt       <= '0;
            r_is_div    <= i_req_op[1];
            r_sa        <= w_sa_in;
            r_sb        <= w_sb_in;
            r_b_zero    <= (i_src_b == '0);
            r_a_raw     <= i_src_a;
            r_a         <= w_mag_a;
            r_b         <= w_mag_b;
            r_acc       <= {{XLEN{1'b0}}, w_mag_b};
            r_rem       <= '0;
            r_quo       <= w_mag_a;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
          end
        end
        S_RUN: begin
          if (r_is_div) begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
          end else begin
            r_acc <= w_acc_next;
          end
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(XLEN - 1)) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          if (!r_is_div) begin
            r_res_hi <= w_prod_fix[2*XLEN-1:XLEN];
            r_res_lo <= w_prod_fix[XLEN-1:0];
          end else if (r_b_zero) begin
            r_res_hi <= r_a_raw;
            r_res_lo <= '1;
          end else begin
            r_res_hi <= w_rem_fix;
            r_res_lo <= w_quo_fix;
          end
          r_state     <= S_DONE;
          r_res_valid <= 1'b1;
        end
        S_DONE: begin
          if (i_res_ready) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_res_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_res_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_busy      = r_busy;
  assign o_res_valid = r_res_valid;
  assign o_res_hi    = r_res_hi;
  assign o_res_lo    = r_res_lo;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: scoreboard bench for muldiv_seq.
// Stimulus pushes the hand-computed {HI, LO} into a queue when an operation is
// issued. A monitor pops and compares whenever a result is consumed.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [63:0] v;
  } exp_t;

  exp_t exp_q[$];

  muldiv_seq #(.XLEN(32), .CNT_W(5)) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_op    (req_op),
    .i_src_a     (src_a),
    .i_src_b     (src_b),
    .i_flush     (flush),
    .o_busy      (busy),
    .o_res_valid (res_valid),
    .i_res_ready (res_ready),
    .o_res_hi    (res_hi),
    .o_res_lo    (res_lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every consumed result against the scoreboard head.
  always @(negedge clk) begin
    if (!reset && res_valid) begin
      check("valid_ready_exclusive", 64'(req_ready), 64'd0);
      if (res_ready && !flush) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result: got %h expected no result", {res_hi, res_lo});
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check({e.tag, " result"}, {res_hi, res_lo}, e.v);
        end
      end
    end
  end

  // Drive a request starting just after a posedge; returns just after the accept edge.
  task automatic issue(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp, input bit push);
    req_valid = 1'b1;
    req_op    = op;
    src_a     = a;
    src_b     = b;
    @(negedge clk);
    check({tag, " req_ready"}, 64'(req_ready), 64'd1);
    if (push) push_exp(tag, exp);
    @(posedge clk);
    #1;
    // Scramble request inputs while busy; they must be ignored.
    req_valid = 1'b0;
    req_op    = ~op;
    src_a     = ~a;
    src_b     = 32'h0;
  endtask

  // Count edges from the accept edge until res_valid; expected 33, busy held throughout.
  task automatic wait_result(input string tag);
    int n;
    bit busy_ok;
    n = 0;
    busy_ok = 1'b1;
    while (n < 100) begin
      @(posedge clk);
      n++;
      #1;
      if (res_valid) break;
      if (!busy) busy_ok = 1'b0;
    end
    check({tag, " latency"}, 64'(n), 64'd33);
    check({tag, " busy"}, 64'(busy_ok & busy), 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    issue(tag, op, a, b, exp, 1'b1);
    wait_result(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " req_ready"}, 64'(req_ready), 64'd1);
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " res_valid"}, 64'(res_valid), 64'd0);
    check({tag, " res_hi"}, 64'(res_hi), 64'd0);
    check({tag, " res_lo"}, 64'(res_lo), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation time exceeded limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] hold_hi, hold_lo;
    bit stable, rr_low, no_pulse;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_outputs("por");

    run_op("multu_max",  2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
    run_op("mult_neg",   2'b00, 32'hFFFFFFFD, 32'h00000005, 64'hFFFFFFFF_FFFFFFF1);
    run_op("mult_pos",   2'b00, 32'h00000007, 32'h00000006, 64'h00000000_0000002A);
    run_op("mult_min",   2'b00, 32'h80000000, 32'h80000000, 64'h40000000_00000000);
    run_op("div_neg",    2'b10, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD);
    run_op("div_negdvs", 2'b10, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD);
    run_op("divu",       2'b11, 32'd100,      32'd7,        64'h00000002_0000000E);
    run_op("div_ovf",    2'b10, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
    run_op("divu_zero",  2'b11, 32'h00001234, 32'h00000000, 64'h00001234_FFFFFFFF);
    run_op("div_zero",   2'b10, 32'hFFFFFFF0, 32'h00000000, 64'hFFFFFFF0_FFFFFFFF);

    // Request together with flush in IDLE is not accepted.
    req_valid = 1'b1;
    req_op    = 2'b00;
    src_a     = 32'd9;
    src_b     = 32'd9;
    flush     = 1'b1;
    @(posedge clk);
    #1;
    flush     = 1'b0;
    req_valid = 1'b0;
    check("flush_idle busy", 64'(busy), 64'd0);

    // Back-pressure: hold the result for 10 cycles with a new request waiting.
    res_ready = 1'b0;
    issue("bp_divu", 2'b11, 32'd1000, 32'd10, 64'h00000000_00000064, 1'b1);
    wait_result("bp_divu");
    hold_hi   = res_hi;
    hold_lo   = res_lo;
    req_valid = 1'b1;
    req_op    = 2'b00;
    src_a     = 32'd7;
    src_b     = 32'd6;
    stable    = 1'b1;
    rr_low    = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      if ({res_hi, res_lo} !== {hold_hi, hold_lo} || !res_valid) stable = 1'b0;
      if (req_ready) rr_low = 1'b0;
    end
    check("bp held value", {hold_hi, hold_lo}, 64'h00000000_00000064);
    check("bp stable", 64'(stable), 64'd1);
    check("bp req_ready low", 64'(rr_low), 64'd1);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp idle req_ready", 64'(req_ready), 64'd1);
    check("bp idle res_valid", 64'(res_valid), 64'd0);
    push_exp("bp_mult", 64'h00000000_0000002A);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("bp accepted busy", 64'(busy), 64'd1);
    wait_result("bp_mult");
    @(posedge clk);
    #1;

    // Abort a divide when cnt==15.
    issue("abort_div", 2'b10, 32'd1000, 32'd3, 64'd0, 1'b0);
    repeat (15) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("abort busy", 64'(busy), 64'd0);
    check("abort req_ready", 64'(req_ready), 64'd1);
    check("abort res_valid", 64'(res_valid), 64'd0);
    no_pulse = 1'b1;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (res_valid) no_pulse = 1'b0;
    end
    check("abort no pulse", 64'(no_pulse), 64'd1);
    run_op("after_abort", 2'b00, 32'd2, 32'd3, 64'h00000000_00000006);

    // Reset in the middle of RUN.
    issue("reset_run", 2'b01, 32'h0000FFFF, 32'h0000FFFF, 64'd0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("mid_reset");
    reset = 1'b0;
    @(posedge clk);
    #1;
    run_op("after_reset", 2'b01, 32'd3, 32'd4, 64'h00000000_0000000C);

    check("scoreboard drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative multi-cycle sequencer for the MIPS mult/multu/div/divu instructions.
- Sits beside the EX stage. It accepts one operation through a valid/ready handshake and runs a 32-iteration shift-add multiply or restoring divide. It then presents the {HI, LO} result, held until the pipeline consumes it for the HI/LO write path.
- EX stalls on `busy`. An exception/flush aborts any operation in flight.

Parameters:
- XLEN, 32, operand width; HI/LO width. Only 32 is required to be supported.
- CNT_W, 5, iteration counter width; $clog2(XLEN).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  EX presents an operation.
- req_ready  out  1  sequencer can accept; high only in IDLE.
- req_op  in  2  00 mult, 01 multu, 10 div, 11 divu.
- src_a  in  32  rs value: multiplicand or dividend.
- src_b  in  32  rt value: multiplier or divisor.
- flush  in  1  abort current/pending operation; no result produced.
- busy  out  1  state != IDLE; used for EX stall.
- res_valid  out  1  result available (DONE state).
- res_ready  in  1  consumer takes result this cycle.
- res_hi  out  32  HI: product[63:32] or remainder.
- res_lo  out  32  LO: product[31:0] or quotient.

Behaviour:
- States: IDLE, RUN, FIX, DONE. Reset forces IDLE, counter 0, all internal registers 0. After reset: req_ready=1, busy=0, res_valid=0, res_hi=0, res_lo=0.
- IDLE -> RUN on an edge where req_valid && req_ready && !flush (accept). At accept:
  - latch op;
  - latch |src_a| and |src_b| (magnitude for signed ops, raw for unsigned);
  - latch sign flags: sa = src_a[31] && signed, sb = src_b[31] && signed;
  - cnt = 0.
- RUN, one iteration per cycle, cnt increments. After the iteration with cnt==31, go to FIX. RUN therefore lasts exactly 32 cycles.
  - Multiply: 64-bit accumulator, shift-add on the multiplier LSB.
  - Divide: 33-bit partial remainder, restoring shift-subtract, one quotient bit per iteration, MSB first.
- FIX, one cycle. Apply sign correction and load res_hi/res_lo, then go to DONE.
  - mult: negate the 64-bit product if sa^sb.
  - div: negate the quotient if sa^sb; negate the remainder if sa.
  - Divide by zero (src_b==0, any div op): res_lo=0xFFFFFFFF, res_hi=src_a (original, unnegated), regardless of signedness.
  - div 0x80000000 / 0xFFFFFFFF: res_lo=0x80000000, res_hi=0, with no special trap.
- DONE: res_valid=1 and res_hi/res_lo stable. On an edge with res_ready=1, go to IDLE; res_hi/res_lo keep their last value, res_valid drops.
- Latency: accept edge k -> res_valid high after edge k+33, i.e. 33 cycles after acceptance. With res_ready tied high, req_ready returns after edge k+34.
- flush has priority over everything except reset. When flush=1 at an edge in any state, go to IDLE, cnt=0, and produce no res_valid. res_hi/res_lo are not updated when the flush occurs in RUN.
- Simultaneous events:
  - req_valid and flush together in IDLE: not accepted.
  - res_ready and flush together in DONE: go to IDLE; the result counts as dropped.
  - reset mid-operation: same as power-on reset.
- req_op, src_a and src_b are ignored outside the accept edge. Changes while busy have no effect.
- Only one operation is in flight; there is no queuing.
- res_valid is never asserted in the same cycle as req_ready.

Test Plan:
- Unsigned multiply: multu 0xFFFFFFFF*0xFFFFFFFF -> res_hi=0xFFFFFFFE, res_lo=0x00000001. res_valid must rise exactly 33 cycles after the accept edge, and busy=1 throughout.
- Signed multiply: mult -3*5 (0xFFFFFFFD, 0x00000005) -> res_hi=0xFFFFFFFF, res_lo=0xFFFFFFF1. Also mult 7*6 -> res_hi=0, res_lo=0x2A.
- Divide: div -7/2 -> res_lo=0xFFFFFFFD, res_hi=0xFFFFFFFF. divu 100/7 -> res_lo=0x0000000E, res_hi=0x00000002. div 0x80000000/0xFFFFFFFF -> res_lo=0x80000000, res_hi=0.
- Divide by zero: divu 0x1234/0 and div 0xFFFFFFF0/0 -> res_lo=0xFFFFFFFF, res_hi equals the dividend. Completes in normal latency with no hang.
- Back-pressure: hold res_ready=0 for 10 cycles after res_valid. Outputs must stay stable, and req_ready=0 with req_valid asserted. Release res_ready and the next request is accepted in the cycle following the IDLE return.
- Abort: flush at cnt=15 of a div. Next cycle busy=0, req_ready=1, and no res_valid pulse. The following mult 2*3 gives res_lo=6, res_hi=0. Assert reset during RUN and check all outputs return to reset values next cycle.
